uart_rx: RTL and testbench
==========================

# uart_rx

Byte receiver for the UART path, the receive-side counterpart to the baud clock generator and transmitter. It samples the asynchronous serial line directly on the 3 MHz system clock and times its own bit centres. It recovers 8N1 frames (optionally 8E1) and presents each byte with a one-cycle valid strobe and error flags to the downstream logic.

## Interface
- CLKS_PER_BIT, default 312, system clocks per bit (3 MHz / 9600 baud); minimum 4.
- clk_i  input  1  system clock, 3 MHz.
- rst_ni  input  1  asynchronous active-low reset.
- rx_i  input  1  serial line, asynchronous, idle high.
- data_o  output  8  last correctly framed byte.
- valid_o  output  1  one-cycle pulse when data_o has been updated.
- frame_err_o  output  1  one-cycle pulse when the stop bit is sampled low.
- parity_err_o  output  1  one-cycle pulse on a parity mismatch; constant 0 when parity is compiled out.
- busy_o  output  1  high whenever the state is not IDLE.

## Operation
- rx_i passes through a 2-flop synchronizer to give rx_s. Both flops reset to 1.
- Constants: H = CLKS_PER_BIT/2 (integer division), P = CLKS_PER_BIT. The bit counter is $clog2(P) bits wide, and the bit index is 3 bits wide.
- States: IDLE, START, DATA, PARITY (only when parity is compiled in), STOP, WAIT_HIGH.
- IDLE: when rx_s = 0, go to START with cnt = 0.
- START: at cnt = H-1, check rx_s.
  - rx_s = 0: go to DATA with cnt = 0 and idx = 0.
  - rx_s = 1: treat as a glitch and return to IDLE. No flags are raised.
- DATA: at cnt = P-1, right-shift rx_s into the shift register MSB, so bits arrive LSB first.
  - cnt restarts at 0 and idx increments.
  - After idx = 7, go to PARITY if compiled in, otherwise to STOP.
- STOP: at cnt = P-1, sample rx_s.
  - rx_s = 1: load data_o from the shift register, pulse valid_o, go to IDLE.
  - rx_s = 0: pulse frame_err_o, leave data_o unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s = 1, then go to IDLE. This covers break conditions and a line stuck low.
- Returning to IDLE at the stop-bit centre allows a start bit that immediately follows (back-to-back frames).
- Reset values: data_o = 0x00, valid_o = 0, frame_err_o = 0, parity_err_o = 0, busy_o = 0, state = IDLE, shift register and counters = 0.
- Asserting reset mid-frame aborts the frame immediately. No flags are produced.

## Timing
- Let t0 be the clock edge at which IDLE sees rx_s = 0. This is 2 to 3 edges after rx_i falls.
- Start check at edge t0+H. Data bit k is sampled at edge t0+H+(k+1)·P.
- Without parity:
  - Stop is sampled at edge t0+H+9P.
  - valid_o (or frame_err_o) is high for exactly one cycle following that edge.
- With parity: all post-data events shift by +P.
- Default P = 312: valid_o follows t0 by 156 + 2808 = 2964 cycles.
- Flags never assert in the same cycle as one another, except valid_o with parity_err_o.
- No backpressure: a consumer that misses the pulse loses the byte. data_o stays stable until the next valid_o.

## Configuration
- UART_RX_PARITY_EN defined:
  - The PARITY state samples an even-parity bit at cnt = P-1.
  - In STOP, a good stop bit pulses valid_o. If the XOR of the 8 data bits and the parity bit is 1, parity_err_o pulses in the same cycle.
- Undefined: no PARITY state exists and parity_err_o is tied to 0.

## Structure
- Package uart_pkg holds:
  - the rx state enum;
  - the default CLKS_PER_BIT = 312;
  - the data width of 8, shared with the baud generator and transmitter.
- Sub-module uart_sync2 is a generic 2-flop synchronizer with reset value 1, reusable for other asynchronous inputs.

## Test plan
- 0xA5 sent at 312 clocks/bit → exactly one valid_o pulse, data_o = 0xA5, 2964 ±2 cycles after the rx_i fall; no error flags.
- rx_i low for 100 cycles, then high → no valid_o and no frame_err_o; busy_o returns to 0 within 160 cycles.
- 0x3C sent with the stop bit low, after a previous good byte 0x11:
  - frame_err_o pulses once and data_o stays 0x11.
  - Line then held low for 5000 cycles → no further events and busy_o stays 1.
  - Line raised, then 0x00 sent → valid_o pulses with data_o = 0x00.
- Back-to-back 0x00 then 0xFF with no idle gap → two valid_o pulses exactly 3120 cycles apart, with data 0x00 then 0xFF.
- rst_ni pulsed low during data bit 3 of 0x55 → all outputs are 0 while reset is asserted and no flags follow. The next 0x55 frame is received correctly.
- With UART_RX_PARITY_EN, 0x01 sent with parity bit 0 → valid_o and parity_err_o pulse in the same cycle with data_o = 0x01. 0x01 sent with parity bit 1 → valid_o pulses only.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing, data width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // 3 MHz system clock / 9600 baud
  localparam int UART_CLKS_PER_BIT = 312;
  // Byte width common to the baud generator, transmitter and receiver
  localparam int UART_DATA_W       = 8;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  // Even parity: the data bits plus the parity bit must XOR to 0
  function automatic logic even_par_err(input logic [UART_DATA_W-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic 2-flop synchronizer for an asynchronous single-bit input, resets to 1.
// Latency: 2 clk_i edges from input change to q_o.
// Backpressure: none.
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture; reset to 1 so an idle-high line is not mistaken for a start bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART byte receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined), bit centres timed from the start edge.
// Latency: valid_o follows the start-detect edge by CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (+CLKS_PER_BIT with parity).
// Backpressure: none; valid_o is a one-cycle pulse and a missed byte is lost, data_o holds until the next valid_o.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rx_i,
  output logic [UART_DATA_W-1:0] data_o,
  output logic                   valid_o,
  output logic                   frame_err_o,
  output logic                   parity_err_o,
  output logic                   busy_o
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  // Start bit is checked at its centre, every later bit one full period after the previous sample
  localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        IDX_LAST = 3'(UART_DATA_W - 1);

  rx_state_t              r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic [UART_DATA_W-1:0] r_data;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   w_rx_s;
  logic                   w_half;
  logic                   w_full;
`ifdef UART_RX_PARITY_EN
  logic                   r_par;
  logic                   r_perr;
`endif

  uart_sync2 u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (w_rx_s)
  );

  assign w_half = (r_cnt == HALF_M1);
  assign w_full = (r_cnt == FULL_M1);

  // Frame FSM: bit-centre timing, LSB-first shift, stop/parity checks and one-cycle result strobes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
      case (r_state)
        RX_IDLE: begin
          if (!w_rx_s) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (w_half) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            // A line that is high again at the start-bit centre was only a glitch
            r_state <= w_rx_s ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[UART_DATA_W-1:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= RX_PARITY;
`else
              r_state <= RX_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_par   <= w_rx_s;
            r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (w_full) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              // Back to IDLE at the stop centre so a directly following start bit is caught
              r_data  <= r_shift;
              r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_perr  <= even_par_err(r_shift, r_par);
`endif
              r_state <= RX_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= RX_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          // Break or stuck-low line: no new frame until the line returns to idle
          if (w_rx_s) begin
            r_state <= RX_IDLE;
          end
        end
        default: begin
          r_state <= RX_IDLE;
        end
      endcase
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_ferr;
  assign busy_o      = (r_state != RX_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = r_perr;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames driven on rx_i, expected strobes queued and matched by a monitor.
// Latency: checks exact start-to-valid latency and back-to-back frame spacing.
// Backpressure: n/a (receiver has none).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int P = 312;
  localparam int H = P / 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef struct packed {
    logic       v;
    logic       f;
    logic       p;
    logic [7:0] d;
  } evt_t;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       busy_o;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_evt = 0;
  int   ev_cyc_last = 0;
  int   ev_cyc_prev = 0;
  int   last_fall = 0;
  int   snap;
  evt_t exp_q[$];
  evt_t mon_e;

  uart_rx #(.CLKS_PER_BIT(P)) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue
  always @(negedge clk_i) begin
    if (valid_o === 1'b1 || frame_err_o === 1'b1 || parity_err_o === 1'b1) begin
      n_evt++;
      ev_cyc_prev = ev_cyc_last;
      ev_cyc_last = cyc;
      if (exp_q.size() == 0) begin
        check_eq("spurious_evt", {29'd0, valid_o, frame_err_o, parity_err_o}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("evt_flags", {29'd0, valid_o, frame_err_o, parity_err_o},
                 {29'd0, mon_e.v, mon_e.f, mon_e.p});
        check_eq("evt_data", {24'd0, data_o}, {24'd0, mon_e.d});
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (P) @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  // Start bit, 8 data bits LSB first, optional parity, stop; line is left at the stop level
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    last_fall = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) rx_i = 1'b1;
`endif
    drive_bit(stop);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk_i);
    check_eq(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    rx_i   = 1'b1;
    repeat (5) @(negedge clk_i);
    check_eq("rst_data",  {24'd0, data_o}, 32'd0);
    check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
    check_eq("rst_ferr",  {31'd0, frame_err_o}, 32'd0);
    check_eq("rst_perr",  {31'd0, parity_err_o}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy_o}, 32'd0);
    rst_ni = 1'b1;
    idle(20);

    // Single good byte; first edge after the fall is last_fall, start seen 2 edges later,
    // valid registered H+9P (+P with parity) edges after that
    exp_q.push_back('{v: 1'b1, f: 1'b0, p: 1'b0, d: 8'hA5});
    send_frame(8'hA5, ^8'hA5, 1'b1);
    wait_drain("drain_a5", 2 * P);
    check_eq("lat_a5", ev_cyc_last - last_fall, 2 + H + (FRAME_BITS - 1) * P);
    check_eq("hold_a5", {24'd0, data_o}, 32'hA5);
    idle(50);

    // Short low pulse is rejected at the start-bit centre
    snap = n_evt;
    rx_i = 1'b0;
    repeat (100) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (60) @(negedge clk_i);
    check_eq("glitch_busy", {31'd0, busy_o}, 32'd0);
    idle(300);
    check_eq("glitch_evts", n_evt - snap, 32'd0);

    // Good byte, then a framing error that must leave data_o alone
    exp_q.push_back('{v: 1'b1, f: 1'b0, p: 1'b0, d: 8'h11});
    send_frame(8'h11, ^8'h11, 1'b1);
    idle(20);
    exp_q.push_back('{v: 1'b0, f: 1'b1, p: 1'b0, d: 8'h11});
    send_frame(8'h3C, ^8'h3C, 1'b0);
    wait_drain("drain_ferr", 2 * P);
    snap = n_evt;
    repeat (5000) @(negedge clk_i);
    check_eq("stuck_busy", {31'd0, busy_o}, 32'd1);
    check_eq("stuck_evts", n_evt - snap, 32'd0);
    check_eq("stuck_data", {24'd0, data_o}, 32'h11);
    idle(50);
    exp_q.push_back('{v: 1'b1, f: 1'b0, p: 1'b0, d: 8'h00});
    send_frame(8'h00, ^8'h00, 1'b1);
    wait_drain("drain_after_break", 2 * P);
    idle(50);

    // Back-to-back frames, no idle between stop and next start
    exp_q.push_back('{v: 1'b1, f: 1'b0, p: 1'b0, d: 8'h00});
    exp_q.push_back('{v: 1'b1, f: 1'b0, p: 1'b0, d: 8'hFF});
    send_frame(8'h00, ^8'h00, 1'b1);
    send_frame(8'hFF, ^8'hFF, 1'b1);
    wait_drain("drain_b2b", 2 * P);
    check_eq("b2b_spacing", ev_cyc_last - ev_cyc_prev, FRAME_BITS * P);
    check_eq("b2b_data", {24'd0, data_o}, 32'hFF);
    idle(50);

    // Reset in the middle of data bit 3, held until the line is idle again
    snap = n_evt;
    fork
      send_frame(8'h55, ^8'h55, 1'b1);
      begin
        repeat (4 * P + H) @(negedge clk_i);
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("mid_rst_data",  {24'd0, data_o}, 32'd0);
        check_eq("mid_rst_valid", {31'd0, valid_o}, 32'd0);
        check_eq("mid_rst_ferr",  {31'd0, frame_err_o}, 32'd0);
        check_eq("mid_rst_perr",  {31'd0, parity_err_o}, 32'd0);
        check_eq("mid_rst_busy",  {31'd0, busy_o}, 32'd0);
      end
    join
    idle(20);
    rst_ni = 1'b1;
    idle(2 * P);
    check_eq("post_rst_evts", n_evt - snap, 32'd0);
    exp_q.push_back('{v: 1'b1, f: 1'b0, p: 1'b0, d: 8'h55});
    send_frame(8'h55, ^8'h55, 1'b1);
    wait_drain("drain_post_rst", 2 * P);
    idle(50);

`ifdef UART_RX_PARITY_EN
    // 0x01 has odd weight: parity bit 0 is wrong, 1 is right
    exp_q.push_back('{v: 1'b1, f: 1'b0, p: 1'b1, d: 8'h01});
    send_frame(8'h01, 1'b0, 1'b1);
    wait_drain("drain_par_bad", 2 * P);
    idle(50);
    exp_q.push_back('{v: 1'b1, f: 1'b0, p: 1'b0, d: 8'h01});
    send_frame(8'h01, 1'b1, 1'b1);
    wait_drain("drain_par_good", 2 * P);
    idle(50);
`endif

    check_eq("final_queue", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
